// File: rtl/icg_idle_ctrl.sv
// Per-unit clock-gating sequencer: gates each unit's clock after a programmable idle
// run, and restarts it on activity or wake request, acknowledging once settled.
module icg_idle_ctrl #(
  parameter int NUM_UNIT   = 4,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  cp0_icg_en,
  input  logic [IDLE_CNT_W-1:0] cp0_idle_thresh,
  input  logic                  pad_yy_icg_scan_en,
  input  logic [NUM_UNIT-1:0]   unit_busy,
  input  logic [NUM_UNIT-1:0]   unit_wake_req,
  output logic [NUM_UNIT-1:0]   unit_wake_ack,
  output logic [NUM_UNIT-1:0]   unit_module_en,
  output logic [NUM_UNIT-1:0]   unit_clk_off,
  output logic                  all_clk_off
);

  typedef enum logic [1:0] {
    ST_ON   = 2'b00,
    ST_CNT  = 2'b01,
    ST_OFF  = 2'b10,
    ST_WAKE = 2'b11
  } state_t;

  localparam logic [IDLE_CNT_W-1:0] WAKE_LOAD = IDLE_CNT_W'(WAKE_DLY);

  if ((WAKE_DLY < 1) || (WAKE_DLY > (2**IDLE_CNT_W) - 1)) begin : g_bad_wake_dly
    $error("icg_idle_ctrl: WAKE_DLY must lie in 1 .. 2**IDLE_CNT_W-1");
  end

  for (genvar gi = 0; gi < NUM_UNIT; gi++) begin : g_unit
    state_t                r_state;
    state_t                w_state_next;
    logic [IDLE_CNT_W-1:0] r_cnt;
    logic [IDLE_CNT_W-1:0] w_cnt_next;
    logic                  r_en;
    logic                  w_en_next;
    logic                  w_block;

    assign w_block = unit_busy[gi] | unit_wake_req[gi] | ~cp0_icg_en | pad_yy_icg_scan_en;

    always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
        r_state <= ST_ON;
        r_cnt   <= '0;
        r_en    <= 1'b1;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        r_en    <= w_en_next;
      end
    end

    // Threshold is sampled only on entry to CNT; WAKE runs to completion regardless of inputs.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_en_next    = r_en;
      case (r_state)
        ST_ON: begin
          w_en_next = 1'b1;
          if (!w_block && (cp0_idle_thresh != '0)) begin
            w_state_next = ST_CNT;
            w_cnt_next   = cp0_idle_thresh;
          end
        end
        ST_CNT: begin
          if (w_block) begin
            w_state_next = ST_ON;
            w_cnt_next   = '0;
          end else if (r_cnt == IDLE_CNT_W'(1)) begin
            w_state_next = ST_OFF;
            w_en_next    = 1'b0;
          end else begin
            w_cnt_next = r_cnt - IDLE_CNT_W'(1);
          end
        end
        ST_OFF: begin
          w_en_next = 1'b0;
          if (w_block) begin
            w_state_next = ST_WAKE;
            w_en_next    = 1'b1;
            w_cnt_next   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          w_en_next = 1'b1;
          if (r_cnt == IDLE_CNT_W'(1)) begin
            w_state_next = ST_ON;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - IDLE_CNT_W'(1);
          end
        end
      endcase
    end

    assign unit_wake_ack[gi]  = (r_state == ST_ON) & unit_wake_req[gi];
    assign unit_module_en[gi] = r_en | pad_yy_icg_scan_en;
    assign unit_clk_off[gi]   = (r_state == ST_OFF);
  end

  assign all_clk_off = &unit_clk_off;

endmodule

// File: tb/tb_icg_idle_ctrl.sv
// Directed bench for icg_idle_ctrl: a cycle-level idle-run/wake-timer model checked on
// every falling edge, plus literal expectations at the key cycles of each scenario.
module tb_icg_idle_ctrl;

  localparam int NU = 4;
  localparam int W  = 8;
  localparam int WD = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          icg_en;
  logic [W-1:0]  thresh;
  logic          scan;
  logic [NU-1:0] busy;
  logic [NU-1:0] req;
  logic [NU-1:0] ack;
  logic [NU-1:0] men;
  logic [NU-1:0] coff;
  logic          aoff;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  icg_idle_ctrl #(.NUM_UNIT(NU), .IDLE_CNT_W(W), .WAKE_DLY(WD)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_b),
    .cp0_icg_en         (icg_en),
    .cp0_idle_thresh    (thresh),
    .pad_yy_icg_scan_en (scan),
    .unit_busy          (busy),
    .unit_wake_req      (req),
    .unit_wake_ack      (ack),
    .unit_module_en     (men),
    .unit_clk_off       (coff),
    .all_clk_off        (aoff)
  );

  always #5 clk = ~clk;

  // Model: run = index of the current idle-countdown cycle (0 = not counting),
  // lat = threshold captured when the run began, wl = wake cycles still to go.
  int run [NU];
  int lat [NU];
  int wl  [NU];
  bit off [NU];

  initial begin
    for (int u = 0; u < NU; u++) begin
      run[u] = 0; lat[u] = 0; wl[u] = 0; off[u] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      bit blk;
      blk = busy[u] | req[u] | !icg_en | scan;
      if (!rst_b) begin
        run[u] = 0; lat[u] = 0; wl[u] = 0; off[u] = 1'b0;
      end else if (wl[u] > 0) begin
        wl[u] = wl[u] - 1;
      end else if (off[u]) begin
        if (blk) begin
          off[u] = 1'b0;
          wl[u]  = WD;
        end
      end else if (blk) begin
        run[u] = 0;
      end else if (run[u] == 0) begin
        if (thresh != 0) begin
          lat[u] = int'(thresh);
          run[u] = 1;
        end
      end else if (run[u] == lat[u]) begin
        off[u] = 1'b1;
        run[u] = 0;
      end else begin
        run[u] = run[u] + 1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [NU-1:0] e_ack, e_men, e_off;
      for (int u = 0; u < NU; u++) begin
        e_off[u] = off[u];
        e_men[u] = !off[u] | scan;
        e_ack[u] = !off[u] && (wl[u] == 0) && (run[u] == 0) && req[u];
      end
      cmp("model_ack", 32'(ack), 32'(e_ack));
      cmp("model_module_en", 32'(men), 32'(e_men));
      cmp("model_clk_off", 32'(coff), 32'(e_off));
      cmp("model_all_clk_off", 32'(aoff), 32'(&e_off));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; icg_en = 1'b1; thresh = 8'd4; scan = 1'b0; busy = '0; req = '0;

    // 1: reset values, then a 4-cycle countdown to gating
    cyc(); cyc();
    chk_on = 1'b1;
    @(negedge clk);
    cmp("rst_module_en", 32'(men), 32'hF);
    cmp("rst_clk_off", 32'(coff), 32'h0);
    cmp("rst_ack", 32'(ack), 32'h0);
    cmp("rst_all_off", 32'(aoff), 32'h0);
    cyc(); rst_b = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); @(negedge clk);
      cmp("t1_en_counting", 32'(men), 32'hF);
    end
    cyc(); @(negedge clk);
    cmp("t1_en_gated", 32'(men), 32'h0);
    cmp("t1_clk_off", 32'(coff), 32'hF);
    cmp("t1_all_off", 32'(aoff), 32'h1);

    // 2: wake request on unit0, ack after WAKE_DLY, regate after drop
    for (int c = 0; c <= 9; c++) begin
      cyc();
      req[0] = (c <= 3);
      @(negedge clk);
      cmp("t2_en0", 32'(men[0]), 32'((c >= 1) && (c <= 8)));
      cmp("t2_ack0", 32'(ack[0]), 32'(c == 3));
    end

    // 3: one busy cycle with cnt=2 aborts the countdown; fresh countdown follows
    for (int c = 0; c <= 12; c++) begin
      cyc();
      req[0]  = (c < 3);
      busy[0] = (c == 6);
      @(negedge clk);
      cmp("t3_en0", 32'(men[0]), 32'((c >= 1) && (c <= 11)));
    end

    // 4: scan forces all enables immediately; all_clk_off clears next cycle
    @(negedge clk);
    cmp("t4_all_off_before", 32'(aoff), 32'h1);
    for (int c = 0; c <= 4; c++) begin
      cyc();
      scan = 1'b1;
      @(negedge clk);
      cmp("t4_scan_en", 32'(men), 32'hF);
      cmp("t4_all_off", 32'(aoff), 32'(c == 0));
    end

    // 5: thresh=0, then cp0_icg_en=0, each for 300 idle cycles
    cyc(); scan = 1'b0; thresh = 8'd0;
    for (int c = 0; c < 300; c++) begin
      cyc(); @(negedge clk);
      cmp("t5_thresh0_en", 32'(men), 32'hF);
    end
    cyc(); thresh = 8'd4; icg_en = 1'b0;
    for (int c = 0; c < 300; c++) begin
      cyc(); @(negedge clk);
      cmp("t5_icgoff_clkoff", 32'(coff), 32'h0);
    end
    cyc(); icg_en = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    cmp("t5_regated", 32'(coff), 32'hF);

    // 6: reset during unit1 WAKE returns to ON with no stale ack
    cyc(); req[1] = 1'b1;
    cyc(); rst_b = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    cmp("t6_in_wake_en1", 32'(men[1]), 32'h1);
    cyc(); rst_b = 1'b1;
    @(negedge clk);
    cmp("t6_post_rst_en", 32'(men), 32'hF);
    cmp("t6_post_rst_ack", 32'(ack), 32'h0);
    cmp("t6_post_rst_off", 32'(coff), 32'h0);
    for (int c = 0; c < 8; c++) begin
      cyc(); @(negedge clk);
      cmp("t6_no_stale_ack", 32'(ack), 32'h0);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
